// File: rtl/control_fsm.sv
// Multi-cycle RV32 subset control FSM: fetch/execute/memory/writeback sequencing
// with an imem/dmem wait watchdog, trap generation and a retired-instruction counter.
module control_fsm #(
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic        f7,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pcEn,
    output logic        branch,
    output logic [1:0]  jump,
    output logic        regWrite,
    output logic [1:0]  resultSrc,
    output logic [1:0]  inmSrc,
    output logic        aluSrc,
    output logic [2:0]  aluControl,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);

    state_t      state;
    state_t      next_state;
    state_t      cur;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic        f7_q;
    logic [7:0]  wd_cnt;
    logic [1:0]  next_cause;
    logic        wd_hit;
    logic        is_alu;
    logic        is_st;
    logic        alu_ok;
    logic [2:0]  alu_dec;

    // rst overrides the decoded state so outputs show RST values while it is held
    assign cur    = rst ? ST_RST : state;
    assign wd_hit = (wd_cnt == WD_LAST);
    assign is_alu = (op_q == OP_R) || (op_q == OP_I);
    assign is_st  = (op_q == OP_ST);

    // ALU operation decode from the latched funct3/funct7
    always_comb begin
        alu_ok  = 1'b1;
        alu_dec = 3'b000;
        case (f3_q)
            3'b000:  alu_dec = ((op_q == OP_R) && f7_q) ? 3'b001 : 3'b000;
            3'b111:  alu_dec = 3'b010;
            3'b110:  alu_dec = 3'b011;
            3'b010:  alu_dec = 3'b101;
            default: alu_ok  = 1'b0;
        endcase
    end

    // Next-state and control output decode
    always_comb begin
        next_state = state;
        next_cause = trapCause;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pcEn       = 1'b0;
        branch     = 1'b0;
        jump       = 2'b00;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        inmSrc     = 2'b00;
        aluSrc     = 1'b0;
        aluControl = 3'b000;
        trap       = 1'b0;
        case (cur)
            ST_RST: begin
                pcEn       = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = ST_EXEC;
                end else if (wd_hit) begin
                    next_state = ST_TRAP;
                    next_cause = 2'b10;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (is_alu && alu_ok) begin
                    regWrite   = 1'b1;
                    aluSrc     = (op_q == OP_I);
                    aluControl = alu_dec;
                    pcEn       = 1'b1;
                    jump       = 2'b01;
                    next_state = ST_FETCH;
                end else if (op_q == OP_BEQ) begin
                    aluControl = 3'b001;
                    inmSrc     = 2'b10;
                    branch     = zero;
                    pcEn       = 1'b1;
                    jump       = 2'b01;
                    next_state = ST_FETCH;
                end else if (op_q == OP_JAL) begin
                    inmSrc     = 2'b11;
                    jump       = 2'b10;
                    resultSrc  = 2'b11;
                    regWrite   = 1'b1;
                    pcEn       = 1'b1;
                    next_state = ST_FETCH;
                end else if ((op_q == OP_LD) || is_st) begin
                    aluSrc     = 1'b1;
                    inmSrc     = is_st ? 2'b01 : 2'b00;
                    next_state = ST_MEM;
                end else begin
                    next_state = ST_TRAP;
                    next_cause = 2'b01;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                aluSrc   = 1'b1;
                inmSrc   = is_st ? 2'b01 : 2'b00;
                if (dmem_ack) begin
                    if (is_st) begin
                        pcEn       = 1'b1;
                        jump       = 2'b01;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (wd_hit) begin
                    next_state = ST_TRAP;
                    next_cause = 2'b11;
                end else begin
                    next_state = ST_MEM;
                end
            end
            ST_WB: begin
                regWrite   = 1'b1;
                resultSrc  = 2'b01;
                aluSrc     = 1'b1;
                pcEn       = 1'b1;
                jump       = 2'b01;
                next_state = ST_FETCH;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                pcEn       = 1'b1;
                jump       = 2'b11;
                next_state = ST_FETCH;
            end
            default: begin
                next_state = ST_RST;
            end
        endcase
    end

    // State, latched instruction fields, watchdog, trap cause and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RST;
            op_q      <= 7'd0;
            f3_q      <= 3'd0;
            f7_q      <= 1'b0;
            wd_cnt    <= 8'd0;
            trapCause <= 2'b00;
            instret   <= 32'd0;
        end else begin
            state     <= next_state;
            trapCause <= next_cause;
            if ((state == ST_FETCH) && imem_ack) begin
                op_q <= op;
                f3_q <= f3;
                f7_q <= f7;
            end
            // watchdog restarts on every state change, so entering FETCH/MEM clears it
            if (next_state != state) begin
                wd_cnt <= 8'd0;
            end else if ((state == ST_FETCH) || (state == ST_MEM)) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                wd_cnt <= 8'd0;
            end
            if (pcEn && ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB))) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: expected control words for every PC-redirect or
// trap cycle are queued by the stimulus and compared by an independent monitor.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst, f7, zero, imem_ack, dmem_ack;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        imem_req, dmem_req, dmem_we, pcEn, branch, regWrite, aluSrc, trap;
    logic [1:0]  jump, resultSrc, inmSrc, trapCause;
    logic [2:0]  aluControl;
    logic [31:0] instret;

    always #5 clk = ~clk;

    control_fsm #(.WD_LIMIT(255)) dut (
        .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .pcEn(pcEn), .branch(branch),
        .jump(jump), .regWrite(regWrite), .resultSrc(resultSrc), .inmSrc(inmSrc),
        .aluSrc(aluSrc), .aluControl(aluControl), .trap(trap),
        .trapCause(trapCause), .instret(instret)
    );

    typedef struct packed {
        logic [1:0]  jump;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [1:0]  inm_src;
        logic        alu_src;
        logic [2:0]  alu_ctl;
        logic        branch;
        logic        trap;
        logic [1:0]  cause;
        logic        we;
        logic        ireq;
        logic        dreq;
        logic [31:0] instret;
    } exp_t;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;

    int   total = 0;
    int   bad = 0;
    int   dreq_cycles = 0;
    int   we_cycles = 0;
    exp_t exp_q[$];
    string name_q[$];

    function automatic exp_t mk(logic [1:0] j, logic rw, logic [1:0] rs, logic [1:0] is,
                                logic as, logic [2:0] ac, logic br, logic tr,
                                logic [1:0] c, logic we, logic dreq, logic [31:0] ir);
        exp_t e;
        e = '{j, rw, rs, is, as, ac, br, tr, c, we, 1'b0, dreq, ir};
        return e;
    endfunction

    task automatic push(string n, exp_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ireq;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step;
        check("imem_req_arrives", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic wait_dreq;
        for (int i = 0; i < 20 && dmem_req !== 1'b1; i++) step;
        check("dmem_req_arrives", {31'd0, dmem_req}, 32'd1);
    endtask

    task automatic fetch(logic [6:0] o, logic [2:0] f, logic s, logic z, int dly);
        wait_ireq;
        repeat (dly) step;
        op = o; f3 = f; f7 = s; zero = z; imem_ack = 1'b1;
        step;
        imem_ack = 1'b0;
    endtask

    task automatic mem(int dly);
        wait_dreq;
        repeat (dly) step;
        dmem_ack = 1'b1;
        step;
        dmem_ack = 1'b0;
    endtask

    // Monitor: every redirect (pcEn with non-reset jump) or trap cycle consumes one expectation
    always @(negedge clk) begin
        exp_t act;
        if (dmem_req === 1'b1) dreq_cycles++;
        if (dmem_req === 1'b1 && dmem_we === 1'b1) we_cycles++;
        if ((pcEn === 1'b1 && jump !== 2'b00) || trap === 1'b1) begin
            act = '{jump, regWrite, resultSrc, inmSrc, aluSrc, aluControl, branch, trap,
                    trapCause, dmem_we, imem_req, dmem_req, instret};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %h want none", act);
            end else begin
                exp_t e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", n, act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) step;
        check("rst_pcEn", {31'd0, pcEn}, 32'd1);
        check("rst_jump", {30'd0, jump}, 32'd0);
        check("rst_reqs", {29'd0, imem_req, dmem_req, regWrite}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_cause", {30'd0, trapCause}, 32'd0);
        rst = 1'b0;

        // ALU instructions, zero-wait fetch
        push("r_add", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0));
        fetch(R, 3'b000, 1'b0, 1'b0, 0);
        step;
        check("instret_after_add", instret, 32'd1);
        push("r_sub", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd1));
        fetch(R, 3'b000, 1'b1, 1'b0, 1);
        push("i_or", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 3'b011, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd2));
        fetch(I, 3'b110, 1'b0, 1'b0, 0);
        push("i_slt", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 3'b101, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd3));
        fetch(I, 3'b010, 1'b1, 1'b0, 2);
        push("r_and", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd4));
        fetch(R, 3'b111, 1'b0, 1'b0, 0);

        // Branches and jal
        push("beq_taken", mk(2'b01, 1'b0, 2'b00, 2'b10, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'd5));
        fetch(BEQ, 3'b000, 1'b0, 1'b1, 0);
        push("beq_not_taken", mk(2'b01, 1'b0, 2'b00, 2'b10, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd6));
        fetch(BEQ, 3'b000, 1'b0, 1'b0, 0);
        push("jal", mk(2'b10, 1'b1, 2'b11, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd7));
        fetch(JAL, 3'b000, 1'b0, 1'b0, 0);

        // Load with ack on the 4th MEM cycle
        push("load_wb", mk(2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd8));
        fetch(LD, 3'b010, 1'b0, 1'b0, 0);
        dreq_cycles = 0;
        we_cycles = 0;
        mem(3);
        check("load_dmem_req_cycles", dreq_cycles, 32'd4);
        check("load_dmem_we_cycles", we_cycles, 32'd0);

        // Store commit, then imem_ack withheld until the watchdog fires
        push("store_commit", mk(2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'd9));
        fetch(ST, 3'b010, 1'b0, 1'b0, 0);
        mem(0);
        push("fetch_timeout", mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'd10));
        wait_ireq;
        repeat (254) step;
        check("imem_req_last_wait", {31'd0, imem_req}, 32'd1);
        step;
        check("imem_req_dropped", {30'd0, imem_req, trap}, 32'd1);

        // Illegal opcode and illegal funct3
        push("illegal_op", mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'd10));
        fetch(7'b0110111, 3'b000, 1'b0, 1'b0, 0);
        push("illegal_f3", mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'd10));
        fetch(R, 3'b001, 1'b0, 1'b0, 0);

        // dmem_ack withheld until the watchdog fires
        push("mem_timeout", mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'd10));
        fetch(LD, 3'b010, 1'b0, 1'b0, 0);
        wait_dreq;
        repeat (254) step;
        check("dmem_req_last_wait", {31'd0, dmem_req}, 32'd1);
        step;
        check("dmem_req_dropped", {30'd0, dmem_req, trap}, 32'd1);
        check("instret_after_traps", instret, 32'd10);

        // Reset in the middle of a store's MEM phase
        fetch(ST, 3'b010, 1'b0, 1'b0, 0);
        wait_dreq;
        step;
        rst = 1'b1;
        step;
        check("midmem_rst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
        check("midmem_rst_pc", {29'd0, pcEn, jump}, 32'd4);
        check("midmem_rst_instret", instret, 32'd0);
        check("midmem_rst_cause", {30'd0, trapCause}, 32'd0);
        rst = 1'b0;
        push("add_after_rst", mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0));
        fetch(R, 3'b000, 1'b0, 1'b0, 0);
        repeat (3) step;
        check("events_outstanding", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
